imm_extend_stage: RTL
=====================

# imm_extend_stage

Registered, parametrised immediate-generation stage for the decode path of the RISC-V core. It accepts `instr[31:7]`, an immediate-format select and a passthrough tag through a valid/ready handshake. It decodes and sign- or zero-extends the immediate to `XLEN` bits and holds results in a 2-entry skid buffer, so back-pressure from execute never creates a combinational path back to fetch. It adds CSR-immediate and shift-amount formats, RV64 extension and an illegal-format flag.

## Interface
- `XLEN`, 32: output immediate width. Legal values are 32 and 64 only.
- `TAG_W`, 5: width of the opaque tag carried alongside the immediate (e.g. rd index).
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `in_valid` input 1: upstream has an instruction.
- `in_ready` output 1: stage can accept this cycle.
- `in_instr` input 25: `instr[31:7]`, indexed [31:7].
- `in_imm_src` input 3: format select.
- `in_tag` input TAG_W: passthrough tag.
- `flush` input 1: synchronous discard of all buffered and incoming entries.
- `out_valid` output 1: `out_imm`/`out_err`/`out_tag` are valid.
- `out_ready` input 1: downstream consumes this cycle.
- `out_imm` output XLEN: extended immediate.
- `out_err` output 1: the format select was illegal.
- `out_tag` output TAG_W: tag of the head entry.

## Operation
- Decode by `in_imm_src`, with S = replicate `instr[31]` to XLEN:
  - 000 I: S, [31:20].
  - 001 S-type: S, [31:25], [11:7].
  - 010 B: S, [7], [30:25], [11:8], 0.
  - 011 J: S, [19:12], [20], [30:21], 0.
  - 100 U: `{[31:12], 12'b0}`, sign-extended from bit 31 to XLEN.
  - 101 Z (CSR zimm): zero-extended [19:15].
  - 110 SH (shamt): zero-extended [24:20] when XLEN=32; [25:20] when XLEN=64.
  - 111: imm = 0, err = 1.
  - For all codes other than 111, err = 0.
- Decode is combinational on the input side. Only the decoded `{imm, err, tag}` is stored.
- Buffer: 2-entry FIFO holding `{imm, err, tag}`, with a count of 0..2.
  - Push = `in_valid & in_ready`.
  - Pop = `out_valid & out_ready`.
- `in_ready` = (count != 2), driven from registered state only. It has no combinational dependence on `out_ready`.
- `out_valid` = (count != 0). The `out_*` data always shows the head entry.
- Push and pop in the same cycle: count is unchanged and order is preserved.
- Full (count = 2): `in_ready` = 0, so no push. A pop that cycle leaves count = 1, and `in_ready` rises the next cycle.
- Empty: `out_valid` = 0. There is no same-cycle bypass from input to output.
- `flush`: next count = 0 and entries are invalidated. A same-cycle push is dropped, and a same-cycle pop is irrelevant. Flush wins over everything except reset.
- Reset (asserted at any time, including mid-transfer): count = 0 immediately, `out_valid` = 0, `out_imm` = 0, `out_err` = 0, `out_tag` = 0, `in_ready` = 1 once `rst_n` deasserts. In-flight entries are lost.
- `out_imm`, `out_err` and `out_tag` are held stable while `out_valid & !out_ready`.
- When `out_valid` = 0, the `out_*` data is don't-care beyond the reset values.

## Timing
- Latency is 1 cycle: a push at edge N gives `out_valid` = 1 after edge N.
- Throughput is 1 per cycle with `out_ready` held high.
- Bubble-free back-pressure: up to 2 entries are accepted after `out_ready` falls.
- After a flush at edge N: `out_valid` = 0 and `in_ready` = 1 after edge N.

## Test plan
- Formats, XLEN=32, `out_ready`=1, one per cycle. Expected `out_imm`, each with err=0 and 1-cycle latency:
  - I `0xFFF00093` -> `0xFFFFFFFF`.
  - S `0xFE112E23` -> `0xFFFFFFFC`.
  - B `0xFE000CE3` -> `0xFFFFFFF8`.
  - J `0x0010006F` -> `0x00000800`.
  - U `0x800000B7` -> `0x80000000`.
  - Z with [19:15]=`0x1F` -> `0x0000001F`.
- XLEN=64:
  - U `0x800000B7` -> `0xFFFFFFFF80000000`.
  - SH with [25:20]=`0x3F` -> `0x000000000000003F`.
  - I `0x7FF00093` -> `0x00000000000007FF`.
- Illegal select 111 with any instr -> `out_imm`=0, `out_err`=1, tag passed through unchanged.
- Back-pressure: `out_ready`=0, offer tags 1, 2, 3 on consecutive cycles.
  - Tags 1 and 2 are accepted; `in_ready`=0 while tag 3 is held.
  - Raise `out_ready`: outputs appear in order 1, 2, 3, with no loss or duplication.
- Flush with count=2 and `in_valid`=1 in the same cycle -> next cycle `out_valid`=0, `in_ready`=1; the flushed and incoming entries never appear.
- Assert `rst_n`=0 asynchronously mid-cycle with count=1:
  - All outputs go to 0 immediately, without waiting for a clock edge.
  - After release, the first push appears 1 cycle later.

Source files
------------

// File: rtl/imm_extend_stage.sv
// imm_extend_stage: decodes and extends a RISC-V immediate into a 2-entry skid FIFO; in: clk, rst_n, in_valid/in_ready, in_instr[31:7], in_imm_src, in_tag, flush; out: out_valid/out_ready, out_imm, out_err, out_tag
module imm_extend_stage #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:7]      in_instr,
  input  logic [2:0]       in_imm_src,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic             out_err,
  output logic [TAG_W-1:0] out_tag
);
  localparam int W = XLEN + 1 + TAG_W;
  logic            s;
  logic [XLEN-1:0] imm;
  logic            err;
  logic [W-1:0]    mem [2];
  logic [1:0]      count;
  logic            wp, rp, push, pop;
  assign s = in_instr[31];
  always_comb begin
    imm = '0;
    err = 1'b0;
    case (in_imm_src)
      3'b000: imm = XLEN'({{52{s}}, in_instr[31:20]});
      3'b001: imm = XLEN'({{52{s}}, in_instr[31:25], in_instr[11:7]});
      3'b010: imm = XLEN'({{52{s}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0});
      3'b011: imm = XLEN'({{44{s}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0});
      3'b100: imm = XLEN'({{32{s}}, in_instr[31:12], 12'b0});
      3'b101: imm = XLEN'({59'b0, in_instr[19:15]});
      3'b110: imm = XLEN == 64 ? XLEN'({58'b0, in_instr[25:20]}) : XLEN'({59'b0, in_instr[24:20]});
      default: err = 1'b1;
    endcase
  end
  assign in_ready  = count != 2'd2;
  assign out_valid = count != 2'd0;
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready;
  assign {out_imm, out_err, out_tag} = mem[rp];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      wp     <= 1'b0;
      rp     <= 1'b0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else if (flush) begin
      count <= '0;
      wp    <= 1'b0;
      rp    <= 1'b0;
    end else begin
      if (push) mem[wp] <= {imm, err, in_tag};
      wp    <= wp ^ push;
      rp    <= rp ^ pop;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end
endmodule
